// File: rtl/dev_irq_ctrl.sv
// Interrupt controller: latches IRQ_IN rising edges as pending bits and runs one REQ/INTA/EOI handshake at a time.
// INTR asserts one cycle after a source becomes pending and enabled; register reads are combinational.
module dev_irq_ctrl #(
  parameter int               DBITS  = 32,
  parameter int               NIRQ   = 4,
  parameter logic [DBITS-1:0] IEADDR = 32'hF0000800,
  parameter logic [DBITS-1:0] IPADDR = 32'hF0000804,
  parameter logic [DBITS-1:0] IDADDR = 32'hF0000808
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [DBITS-1:0] ABUS,
  input  logic             WE,
  input  logic [DBITS-1:0] DBUS_IN,
  output logic [DBITS-1:0] DBUS_OUT,
  input  logic [NIRQ-1:0]  IRQ_IN,
  output logic             INTR,
  input  logic             INTA,
  output logic [3:0]       IRQ_ID
);

  typedef enum logic [1:0] {IDLE, REQ, SVC} stateT;

  stateT           state, stateNext;
  logic [NIRQ-1:0] ie, ip, prevIrq;
  logic [NIRQ-1:0] ipNext, setBits, act, idMask;
  logic            isv, isvNext, intrNext, ackClr;
  logic [3:0]      sel, irqIdNext;
  logic            ieWr, ipWr, eoiWr;
  logic            unusedDbus;

  assign ieWr    = WE && (ABUS == IEADDR);
  assign ipWr    = WE && (ABUS == IPADDR);
  assign eoiWr   = WE && (ABUS == IDADDR);
  assign setBits = IRQ_IN & ~prevIrq;
  assign act     = ip & ie;

  assign unusedDbus = ^DBUS_IN[DBITS-1:NIRQ];

  // Lowest index wins: scan from the top so lower indices overwrite.
  always_comb begin
    sel = 4'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (act[i]) sel = 4'(i);
    end
  end

  always_comb begin
    idMask = '0;
    for (int i = 0; i < NIRQ; i++) begin
      idMask[i] = (IRQ_ID == 4'(i));
    end
  end

  always_comb begin
    stateNext = state;
    intrNext  = INTR;
    isvNext   = isv;
    irqIdNext = IRQ_ID;
    ackClr    = 1'b0;
    case (state)
      IDLE: begin
        if (|act) begin
          irqIdNext = sel;
          intrNext  = 1'b1;
          stateNext = REQ;
        end
      end
      REQ: begin
        if (INTA) begin
          ackClr    = 1'b1;
          isvNext   = 1'b1;
          intrNext  = 1'b0;
          stateNext = SVC;
        end else if (!(|(act & idMask))) begin
          // Source masked or cleared by software: withdraw, re-pick from IDLE.
          intrNext  = 1'b0;
          stateNext = IDLE;
        end
      end
      SVC: begin
        if (eoiWr) begin
          isvNext   = 1'b0;
          stateNext = IDLE;
        end
      end
      default: begin
        intrNext  = 1'b0;
        isvNext   = 1'b0;
        stateNext = IDLE;
      end
    endcase
  end

  // New rises win over a software clear; the acknowledge clear wins over both.
  always_comb begin
    ipNext = ip | setBits;
    if (ipWr) ipNext = (ip & ~DBUS_IN[NIRQ-1:0]) | setBits;
    if (ackClr) ipNext = ipNext & ~idMask;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      ie      <= '0;
      ip      <= '0;
      prevIrq <= '0;
      isv     <= 1'b0;
      INTR    <= 1'b0;
      IRQ_ID  <= 4'd0;
    end else begin
      state   <= stateNext;
      ip      <= ipNext;
      prevIrq <= IRQ_IN;
      isv     <= isvNext;
      INTR    <= intrNext;
      IRQ_ID  <= irqIdNext;
      if (ieWr) ie <= DBUS_IN[NIRQ-1:0];
    end
  end

  always_comb begin
    DBUS_OUT = '0;
    if (!WE) begin
      if (ABUS == IEADDR)      DBUS_OUT = DBITS'(ie);
      else if (ABUS == IPADDR) DBUS_OUT = DBITS'(ip);
      else if (ABUS == IDADDR) DBUS_OUT = DBITS'({isv, INTR, 3'b000, IRQ_ID});
    end
  end

endmodule

// File: tb/tb_dev_irq_ctrl.sv
// Scoreboard bench for dev_irq_ctrl: stimulus queues expected reads and INTR rises, a negedge monitor checks them.
module tb_dev_irq_ctrl;

  localparam logic [31:0] IEA = 32'hF0000800;
  localparam logic [31:0] IPA = 32'hF0000804;
  localparam logic [31:0] IDA = 32'hF0000808;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] ABUS;
  logic        WE;
  logic [31:0] DBUS_IN;
  logic [31:0] DBUS_OUT;
  logic [3:0]  IRQ_IN;
  logic        INTR;
  logic        INTA;
  logic [3:0]  IRQ_ID;

  dev_irq_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N), .ABUS(ABUS), .WE(WE), .DBUS_IN(DBUS_IN),
    .DBUS_OUT(DBUS_OUT), .IRQ_IN(IRQ_IN), .INTR(INTR), .INTA(INTA), .IRQ_ID(IRQ_ID)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] rdExpQ[$];
  string       rdNameQ[$];
  int          expIdQ[$];
  int          expCycQ[$];
  bit          rdReq = 1'b0;
  bit          intrPrev = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: read responses when a read is presented, request id/timing on each INTR rise.
  always @(negedge CLK) begin
    if (rdReq) begin
      if (rdExpQ.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_underflow got=%h required=<queued expectation>", DBUS_OUT);
      end else begin
        logic [31:0] e;
        string       n;
        e = rdExpQ.pop_front();
        n = rdNameQ.pop_front();
        checks++;
        if (DBUS_OUT !== e) begin
          failures++;
          $display("FAIL %s got=%h required=%h", n, DBUS_OUT, e);
        end
      end
    end
    if (INTR === 1'b1 && !intrPrev) begin
      if (expIdQ.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_intr cyc=%0d id=%0d required=no request", cyc, IRQ_ID);
      end else begin
        int ei, ec;
        ei = expIdQ.pop_front();
        ec = expCycQ.pop_front();
        checks += 2;
        if (IRQ_ID !== 4'(ei)) begin
          failures++;
          $display("FAIL intr_id got=%0d required=%0d", IRQ_ID, ei);
        end
        if (cyc != ec) begin
          failures++;
          $display("FAIL intr_cycle got=%0d required=%0d", cyc, ec);
        end
      end
    end
    intrPrev = (INTR === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ABUS = a; WE = 1'b1; DBUS_IN = d;
    tick(1);
    WE = 1'b0; ABUS = '0; DBUS_IN = '0;
  endtask

  task automatic rdChk(input logic [31:0] a, input logic [31:0] e, input string n);
    ABUS = a; WE = 1'b0;
    rdExpQ.push_back(e);
    rdNameQ.push_back(n);
    rdReq = 1'b1;
    tick(1);
    rdReq = 1'b0; ABUS = '0;
  endtask

  // An INTR rise for `id` is expected `dly` cycles after the current one.
  task automatic expectIntr(input int id, input int dly);
    expIdQ.push_back(id);
    expCycQ.push_back(cyc + dly);
  endtask

  task automatic rise(input logic [3:0] bits);
    IRQ_IN = bits;
    tick(1);
    IRQ_IN = 4'b0000;
  endtask

  task automatic ack();
    INTA = 1'b1;
    tick(1);
    INTA = 1'b0;
  endtask

  task automatic waitIntr(input string n);
    int k = 0;
    while (INTR !== 1'b1 && k < 20) begin
      tick(1);
      k++;
    end
    checks++;
    if (INTR !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout got INTR=%b required=1", n, INTR);
    end
  endtask

  initial begin
    RESET_N = 1'b0; ABUS = '0; WE = 1'b0; DBUS_IN = '0; IRQ_IN = '0; INTA = 1'b0;
    tick(3);
    RESET_N = 1'b1;
    tick(1);
    rdChk(IEA, 32'h0, "rst_ie");
    rdChk(IPA, 32'h0, "rst_ip");
    rdChk(IDA, 32'h0, "rst_id");

    // T1: single source through the full handshake
    wr(IEA, 32'h3);
    rdChk(IEA, 32'h3, "t1_ie");
    expectIntr(1, 2);
    rise(4'b0010);
    rdChk(IPA, 32'h2, "t1_ip_set");
    rdChk(IDA, 32'h081, "t1_id_req");
    ack();
    rdChk(IDA, 32'h101, "t1_id_svc");
    rdChk(IPA, 32'h0, "t1_ip_acked");
    wr(IDA, 32'h0);
    rdChk(IDA, 32'h001, "t1_id_eoi");

    // T2: simultaneous rises, lowest index first, then the other after EOI
    wr(IEA, 32'hF);
    expectIntr(0, 2);
    rise(4'b1001);
    rdChk(IPA, 32'h9, "t2_ip_both");
    waitIntr("t2_wait0");
    ack();
    rdChk(IPA, 32'h8, "t2_ip_after_ack");
    rdChk(IDA, 32'h100, "t2_id_svc0");
    expectIntr(3, 2);
    wr(IDA, 32'h0);
    waitIntr("t2_wait3");
    ack();
    wr(IDA, 32'h0);
    rdChk(IPA, 32'h0, "t2_ip_empty");

    // T3: masked source stays pending, enabling it raises the request
    wr(IEA, 32'h0);
    rise(4'b0100);
    rdChk(IPA, 32'h4, "t3_ip_masked");
    tick(3);
    rdChk(IDA, 32'h003, "t3_no_intr");
    expectIntr(2, 2);
    wr(IEA, 32'h4);
    waitIntr("t3_wait2");

    // T4: software clear while requested withdraws; INTA then ignored
    wr(IPA, 32'h4);
    tick(1);
    rdChk(IDA, 32'h002, "t4_withdrawn");
    rdChk(IPA, 32'h0, "t4_ip_cleared");
    ack();
    rdChk(IDA, 32'h002, "t4_inta_ignored");

    // T5: a rise in the same cycle as its W1C keeps the bit pending
    wr(IEA, 32'h0);
    rise(4'b0010);
    rdChk(IPA, 32'h2, "t5_ip_pre");
    IRQ_IN = 4'b0010; ABUS = IPA; WE = 1'b1; DBUS_IN = 32'h2;
    tick(1);
    IRQ_IN = 4'b0000; WE = 1'b0; ABUS = '0; DBUS_IN = '0;
    rdChk(IPA, 32'h2, "t5_set_wins");
    wr(IPA, 32'h2);
    rdChk(IPA, 32'h0, "t5_w1c");

    // Request id is not re-picked when a lower index arrives during REQ
    wr(IEA, 32'hF);
    expectIntr(3, 2);
    rise(4'b1000);
    waitIntr("hold_wait3");
    rise(4'b0001);
    rdChk(IDA, 32'h083, "hold_id3");
    rdChk(IPA, 32'h9, "hold_ip");
    ack();
    rdChk(IPA, 32'h1, "hold_ip_acked");
    expectIntr(0, 2);
    wr(IDA, 32'h0);
    waitIntr("hold_wait0");
    ack();
    wr(IDA, 32'h0);

    // T6: reset while in service clears everything; later EOI is inert
    expectIntr(2, 2);
    rise(4'b0100);
    waitIntr("t6_wait2");
    ack();
    rise(4'b0010);
    rdChk(IDA, 32'h102, "t6_svc");
    rdChk(IPA, 32'h2, "t6_ip_in_svc");
    RESET_N = 1'b0;
    tick(2);
    RESET_N = 1'b1;
    tick(1);
    rdChk(IDA, 32'h0, "t6_id_reset");
    rdChk(IPA, 32'h0, "t6_ip_reset");
    rdChk(IEA, 32'h0, "t6_ie_reset");
    wr(IDA, 32'h0);
    rdChk(IDA, 32'h0, "t6_eoi_inert");
    tick(3);

    checks++;
    if (expIdQ.size() != 0) begin
      failures++;
      $display("FAIL intr_missing got=%0d pending required=0", expIdQ.size());
    end
    checks++;
    if (rdExpQ.size() != 0) begin
      failures++;
      $display("FAIL rd_missing got=%0d pending required=0", rdExpQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
